// File: rtl/ppu_mem_writer.sv
// Host write path into the PPU graphics memories: region decode, single FIFO, one drain per idle cycle.
// Optional PPU_WRITER_VBLANK_ONLY_EN restricts draining to vertical blank.
`timescale 1ns/1ps
module ppu_mem_writer #(
  parameter int DEPTH = 16,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          chipselect,
  input  logic          write,
  input  logic          read,
  input  logic [AW-1:0] address,
  input  logic [31:0]   write_data,
  output logic          waitrequest,
  output logic [31:0]   readdata,
  input  logic          ppu_busy,
  input  logic          vblank,
  output logic          rw_tile_buffer,
  output logic          rw_tile_graphics,
  output logic          rw_sprite_graphics,
  output logic          rw_color_palettes,
  output logic          rw_OAM,
  output logic [8:0]    addr_tile_buffer,
  output logic [10:0]   addr_tile_graphics,
  output logic [10:0]   addr_sprite_graphics,
  output logic [2:0]    addr_color_palettes,
  output logic [7:0]    addr_OAM,
  output logic [31:0]   write_data_tile_buffer,
  output logic [31:0]   write_data_tile_graphics,
  output logic [31:0]   write_data_sprite_graphics,
  output logic [23:0]   write_data_color_palettes,
  output logic [31:0]   write_data_OAM
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]  region;
    logic [10:0] offset;
    logic [31:0] data;
  } wr_req_t;

  wr_req_t        mem [DEPTH];
  wr_req_t        head;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    count;
  logic           err_unmapped;
  logic [2:0]     region;
  logic           accept, push, pop, flush, clr_err, set_err;

  assign region      = address[13:11];
  assign waitrequest = (count == (PW+1)'(DEPTH));
  assign accept      = chipselect & write & ~waitrequest;
  assign push        = accept & (region <= 3'd4);
  assign flush       = accept & (region == 3'd5) & write_data[0];
  assign clr_err     = accept & (region == 3'd5) & write_data[1];
  assign set_err     = accept & region[2] & region[1];
  assign head        = mem[rd_ptr];

`ifdef PPU_WRITER_VBLANK_ONLY_EN
  assign pop = (count != '0) & ~ppu_busy & vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign pop = (count != '0) & ~ppu_busy;
`endif

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= '{region: region, offset: address[10:0], data: write_data};

  // Flush wins over any concurrent pop; the popped entry has already been captured for output.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      err_unmapped <= 1'b0;
      readdata     <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
      if (set_err)      err_unmapped <= 1'b1;
      else if (clr_err) err_unmapped <= 1'b0;
      if (chipselect & read) readdata <= {23'b0, err_unmapped, 1'b0, 7'(count)};
    end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rw_tile_buffer             <= 1'b0;
      rw_tile_graphics           <= 1'b0;
      rw_sprite_graphics         <= 1'b0;
      rw_color_palettes          <= 1'b0;
      rw_OAM                     <= 1'b0;
      addr_tile_buffer           <= '0;
      addr_tile_graphics         <= '0;
      addr_sprite_graphics       <= '0;
      addr_color_palettes        <= '0;
      addr_OAM                   <= '0;
      write_data_tile_buffer     <= '0;
      write_data_tile_graphics   <= '0;
      write_data_sprite_graphics <= '0;
      write_data_color_palettes  <= '0;
      write_data_OAM             <= '0;
    end else begin
      rw_tile_buffer     <= 1'b0;
      rw_tile_graphics   <= 1'b0;
      rw_sprite_graphics <= 1'b0;
      rw_color_palettes  <= 1'b0;
      rw_OAM             <= 1'b0;
      if (pop) begin
        case (head.region)
          3'd0: begin
            rw_tile_buffer         <= 1'b1;
            addr_tile_buffer       <= head.offset[8:0];
            write_data_tile_buffer <= head.data;
          end
          3'd1: begin
            rw_tile_graphics         <= 1'b1;
            addr_tile_graphics       <= head.offset;
            write_data_tile_graphics <= head.data;
          end
          3'd2: begin
            rw_sprite_graphics         <= 1'b1;
            addr_sprite_graphics       <= head.offset;
            write_data_sprite_graphics <= head.data;
          end
          3'd3: begin
            rw_color_palettes         <= 1'b1;
            addr_color_palettes       <= head.offset[2:0];
            write_data_color_palettes <= head.data[23:0];
          end
          3'd4: begin
            rw_OAM         <= 1'b1;
            addr_OAM       <= head.offset[7:0];
            write_data_OAM <= head.data;
          end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_ppu_mem_writer.sv
// Bench for ppu_mem_writer: vector table, directed FIFO/flush/error sequences, randomized order check.
`timescale 1ns/1ps
module tb_ppu_mem_writer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0, reset = 1'b1;
  logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [13:0] address = '0;
  logic [31:0] write_data = '0;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        ppu_busy = 1'b0, vblank = 1'b1;
  logic        rw_tile_buffer, rw_tile_graphics, rw_sprite_graphics, rw_color_palettes, rw_OAM;
  logic [8:0]  addr_tile_buffer;
  logic [10:0] addr_tile_graphics, addr_sprite_graphics;
  logic [2:0]  addr_color_palettes;
  logic [7:0]  addr_OAM;
  logic [31:0] write_data_tile_buffer, write_data_tile_graphics, write_data_sprite_graphics, write_data_OAM;
  logic [23:0] write_data_color_palettes;

  ppu_mem_writer #(.DEPTH(DEPTH), .AW(14)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .write_data(write_data), .waitrequest(waitrequest), .readdata(readdata),
    .ppu_busy(ppu_busy), .vblank(vblank),
    .rw_tile_buffer(rw_tile_buffer), .rw_tile_graphics(rw_tile_graphics),
    .rw_sprite_graphics(rw_sprite_graphics), .rw_color_palettes(rw_color_palettes), .rw_OAM(rw_OAM),
    .addr_tile_buffer(addr_tile_buffer), .addr_tile_graphics(addr_tile_graphics),
    .addr_sprite_graphics(addr_sprite_graphics), .addr_color_palettes(addr_color_palettes),
    .addr_OAM(addr_OAM),
    .write_data_tile_buffer(write_data_tile_buffer), .write_data_tile_graphics(write_data_tile_graphics),
    .write_data_sprite_graphics(write_data_sprite_graphics),
    .write_data_color_palettes(write_data_color_palettes), .write_data_OAM(write_data_OAM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  v;
    logic [10:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
    int          region;
    logic [10:0] ea;
    logic [31:0] ed;
  } vec_t;

  int  errors = 0, checks = 0;
  wr_t got[$];

  function automatic logic [4:0] rw_vec();
    return {rw_OAM, rw_color_palettes, rw_sprite_graphics, rw_tile_graphics, rw_tile_buffer};
  endfunction

  function automatic logic [10:0] port_addr(int r);
    case (r)
      0: return 11'(addr_tile_buffer);
      1: return addr_tile_graphics;
      2: return addr_sprite_graphics;
      3: return 11'(addr_color_palettes);
      default: return 11'(addr_OAM);
    endcase
  endfunction

  function automatic logic [31:0] port_data(int r);
    case (r)
      0: return write_data_tile_buffer;
      1: return write_data_tile_graphics;
      2: return write_data_sprite_graphics;
      3: return 32'(write_data_color_palettes);
      default: return write_data_OAM;
    endcase
  endfunction

  // Reference: what a host write should turn into on the memory side.
  function automatic wr_t model(logic [13:0] a, logic [31:0] d);
    wr_t e;
    int  r = int'(a[13:11]);
    e.v = 5'(1 << r);
    e.a = a[10:0];
    e.d = d;
    if (r == 0) e.a = a[10:0] & 11'h1FF;
    if (r == 3) begin e.a = a[10:0] & 11'h7; e.d = d & 32'h00FF_FFFF; end
    if (r == 4) e.a = a[10:0] & 11'hFF;
    return e;
  endfunction

  always @(negedge clk) begin : mon
    wr_t        g;
    logic [4:0] v;
    int         r;
    v = rw_vec();
    if (reset && v != 5'd0) begin
      r = 0;
      for (int i = 4; i >= 0; i--) if (v[i]) r = i;
      g.v = v; g.a = port_addr(r); g.d = port_data(r);
      got.push_back(g);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(logic [13:0] a, logic [31:0] d);
    int w = 0;
    chipselect = 1'b1; write = 1'b1; address = a; write_data = d;
    while (waitrequest && w < 200) begin tick(); w++; end
    chk("accept_bound", 32'(w < 200), 32'd1);
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic do_read(output logic [31:0] rd);
    chipselect = 1'b1; read = 1'b1;
    tick();
    rd = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic wait_emitted(int base, int n);
    int w = 0;
    while (got.size() - base < n && w < 2000) begin tick(); w++; end
    chk("drain_bound", 32'(w < 2000), 32'd1);
  endtask

  task automatic check_list(string tag, int base, wr_t e[$]);
    chk($sformatf("%s_count", tag), 32'(got.size() - base), 32'(e.size()));
    for (int i = 0; i < e.size() && base + i < got.size(); i++) begin
      chk($sformatf("%s_rw%0d", tag, i), 32'(got[base+i].v), 32'(e[i].v));
      chk($sformatf("%s_addr%0d", tag, i), 32'(got[base+i].a), 32'(e[i].a));
      chk($sformatf("%s_data%0d", tag, i), got[base+i].d, e[i].d);
    end
  endtask

  initial begin
    vec_t        tbl[5];
    wr_t         exp_q[$];
    logic [31:0] rd;
    logic [13:0] a;
    logic [31:0] d;
    int          base;

    tbl[0] = '{14'h0805, 32'hDEADBEEF, 1, 11'h005, 32'hDEADBEEF};
    tbl[1] = '{14'h1803, 32'hFF123456, 3, 11'h003, 32'h00123456};
    tbl[2] = '{14'h07FF, 32'h11111111, 0, 11'h1FF, 32'h11111111};
    tbl[3] = '{14'h17FF, 32'hCAFEF00D, 2, 11'h7FF, 32'hCAFEF00D};
    tbl[4] = '{14'h21AB, 32'h0BADF00D, 4, 11'h0AB, 32'h0BADF00D};

    // Reset state, checked while reset is held.
    #2 reset = 1'b0;
    #1;
    chk("rst_rw", 32'(rw_vec()), 32'd0);
    for (int r = 0; r < 5; r++) begin
      chk($sformatf("rst_addr%0d", r), 32'(port_addr(r)), 32'd0);
      chk($sformatf("rst_data%0d", r), port_data(r), 32'd0);
    end
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_waitrequest", 32'(waitrequest), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    tick();
    do_read(rd);
    chk("rst_status", rd, 32'd0);

    // Single writes per region: N+2 latency, one-cycle pulse, held address.
    foreach (tbl[i]) begin
      do_write(tbl[i].addr, tbl[i].data);
      chk($sformatf("vec%0d_early", i), 32'(rw_vec()), 32'd0);
      tick();
      chk($sformatf("vec%0d_rw", i), 32'(rw_vec()), 32'(1 << tbl[i].region));
      chk($sformatf("vec%0d_addr", i), 32'(port_addr(tbl[i].region)), 32'(tbl[i].ea));
      chk($sformatf("vec%0d_data", i), port_data(tbl[i].region), tbl[i].ed);
      tick();
      chk($sformatf("vec%0d_pulse", i), 32'(rw_vec()), 32'd0);
      chk($sformatf("vec%0d_hold", i), 32'(port_addr(tbl[i].region)), 32'(tbl[i].ea));
    end

    // Fill to full while busy, stall the 17th, then drain in order.
    ppu_busy = 1'b1;
    base = got.size();
    exp_q = {};
    for (int i = 0; i < DEPTH + 1; i++) begin
      a = {3'(i % 5), 11'(i * 37 + 1)};
      d = $urandom;
      exp_q.push_back(model(a, d));
      if (i < DEPTH) do_write(a, d);
    end
    chk("full_wait", 32'(waitrequest), 32'd1);
    do_read(rd);
    chk("full_count", 32'(rd[6:0]), 32'(DEPTH));
    chipselect = 1'b1; write = 1'b1; address = {3'(DEPTH % 5), 11'(DEPTH * 37 + 1)};
    write_data = exp_q[DEPTH].d;
    if (DEPTH % 5 == 3) write_data = 32'hFF000000 | exp_q[DEPTH].d;
    tick(3);
    chk("full_stall", 32'(waitrequest), 32'd1);
    chk("full_no_drain", 32'(got.size() - base), 32'd0);
    ppu_busy = 1'b0;
    do_write(address, write_data);
    wait_emitted(base, DEPTH + 1);
    tick(2);
    chk("full_wait_drop", 32'(waitrequest), 32'd0);
    check_list("full", base, exp_q);

    // Unmapped regions set the sticky error; control bit 1 clears it.
    base = got.size();
    do_write(14'h3800, 32'h12345678);
    tick(4);
    chk("unmap_no_rw", 32'(got.size() - base), 32'd0);
    do_read(rd);
    chk("unmap_err_set", 32'(rd[8]), 32'd1);
    do_write(14'h2800, 32'h2);
    do_read(rd);
    chk("unmap_err_clr", 32'(rd[8]), 32'd0);
    do_write(14'h3123, 32'h0);
    do_read(rd);
    chk("unmap6_err_set", 32'(rd[8]), 32'd1);
    do_write(14'h2800, 32'h2);

    // Flush five queued entries while busy.
    ppu_busy = 1'b1;
    for (int i = 0; i < 5; i++) do_write({3'(i), 11'(i + 8)}, $urandom);
    do_read(rd);
    chk("flush_pre_count", 32'(rd[6:0]), 32'd5);
    do_write(14'h2800, 32'h1);
    do_read(rd);
    chk("flush_count", 32'(rd[6:0]), 32'd0);
    base = got.size();
    ppu_busy = 1'b0;
    tick(6);
    chk("flush_no_rw", 32'(got.size() - base), 32'd0);

    // Flush landing in the same cycle as a pop: that one write still issues.
    ppu_busy = 1'b1;
    exp_q = {};
    for (int i = 0; i < 3; i++) begin
      a = {3'(i + 1), 11'(i * 5 + 2)};
      d = $urandom;
      exp_q.push_back(model(a, d));
      do_write(a, d);
    end
    exp_q = exp_q[0:0];
    base = got.size();
    ppu_busy = 1'b0;
    chipselect = 1'b1; write = 1'b1; address = 14'h2800; write_data = 32'h1;
    tick();
    chipselect = 1'b0; write = 1'b0;
    tick(5);
    check_list("flushpop", base, exp_q);

    // Asynchronous reset mid-drain kills output strobes at once.
    ppu_busy = 1'b1;
    for (int i = 0; i < 5; i++) do_write({3'(i), 11'(i)}, $urandom);
    ppu_busy = 1'b0;
    tick();
    chk("middrain_active", 32'(rw_vec() != 5'd0), 32'd1);
    base = got.size();
    #1 reset = 1'b0;
    #1 chk("middrain_rst_rw", 32'(rw_vec()), 32'd0);
    @(negedge clk) reset = 1'b1;
    tick(6);
    chk("middrain_after", 32'(got.size() - base), 32'd0);
    do_read(rd);
    chk("middrain_count", 32'(rd[6:0]), 32'd0);

`ifdef PPU_WRITER_VBLANK_ONLY_EN
    vblank = 1'b0;
    base = got.size();
    a = 14'h0C21; d = 32'hA5A55A5A;
    exp_q = {};
    exp_q.push_back(model(a, d));
    do_write(a, d);
    tick(5);
    chk("vblank_hold", 32'(got.size() - base), 32'd0);
    vblank = 1'b1;
    tick(3);
    check_list("vblank", base, exp_q);
`endif

    // Randomized traffic with busy toggling; emitted stream must match accepted stream.
    base = got.size();
    exp_q = {};
    for (int i = 0; i < 150; i++) begin
      a = {3'($urandom_range(0, 4)), 11'($urandom)};
      d = $urandom;
      ppu_busy = ($urandom_range(0, 2) == 0) && !waitrequest;
      exp_q.push_back(model(a, d));
      do_write(a, d);
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
    end
    ppu_busy = 1'b0;
    wait_emitted(base, exp_q.size());
    tick(2);
    check_list("rand", base, exp_q);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
